// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit defaults, arbiter FSM states and modulo-N pointer step
package noc_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAIL_BIT = DEF_DATA_W - 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int mod_inc(int v, int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select, first requester at or after ptr wins
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = PW'((int'(ptr) + i) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: packet-locking round-robin drain of input FIFOs into a one-entry output register
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAIL_BIT = DATA_W - 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_empty,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_read_en,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     locked
);
  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel_idx;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
  logic [NUM_IN-1:0] owner_oh, req, sel_oh;
  logic found, slot_free, pop, tail;
  assign owner_oh = NUM_IN'(1) << owner_q;
  assign req = (state_q == LOCKED) ? (~in_empty & owner_oh) : ~in_empty;
  rr_arbiter #(.N(NUM_IN), .PW(PW)) u_rr (
    .req(req), .ptr(rr_ptr_q), .gnt(sel_oh), .idx(sel_idx), .found(found)
  );
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    pop = found && slot_free && !reset;
    sel_data = in_data[int'(sel_idx)*DATA_W +: DATA_W];
    tail = sel_data[TAIL_BIT];
    in_read_en = pop ? sel_oh : '0;
    grant = (state_q == LOCKED) ? owner_oh : in_read_en;
    locked = state_q == LOCKED;
    out_valid_d = pop ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d = pop ? sel_data : out_data_q;
    state_d = pop ? (tail ? IDLE : LOCKED) : state_q;
    owner_d = pop ? sel_idx : owner_q;
    rr_ptr_d = (pop && tail) ? PW'(mod_inc(int'(sel_idx), NUM_IN)) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb_noc_out_arbiter: directed-vector bench with queue-modelled input FIFOs
module tb_noc_out_arbiter;
  logic clk, reset, out_valid, out_ready, locked;
  logic [3:0] in_empty, in_read_en, grant, rd;
  logic [127:0] in_data;
  logic [31:0] out_data;
  logic [31:0] q [4][$];
  logic fifo_err;
  int n_chk, n_err;
  noc_out_arbiter dut (
    .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data),
    .in_read_en(in_read_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant(grant), .locked(locked)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = q[i].size() == 0;
      in_data[i*32 +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
    end
  endtask
  task automatic push(input int i, input logic [31:0] d);
    q[i].push_back(d);
    refresh();
  endtask
  task automatic cyc(input string tag, input logic [3:0] en, input logic [3:0] g,
                     input logic lk, input logic v, input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".en"}, 32'(in_read_en), 32'(en));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".data"}, out_data, d);
    @(posedge clk);
    #1;
  endtask
  always begin
    @(negedge clk);
    rd = in_read_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rd[i]) begin
        if (q[i].size() == 0) fifo_err = 1'b1;
        else void'(q[i].pop_front());
      end
    refresh();
  end
  initial begin
    n_chk = 0;
    n_err = 0;
    fifo_err = 1'b0;
    reset = 1'b1;
    out_ready = 1'b1;
    in_empty = '1;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 4'b0000, 4'b0000, 0, 0, 32'h0);
    @(negedge clk);
    chk("reset.data", out_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // single-flit packets rotate 0,1,2,3 then wrap back to 0
    for (int i = 0; i < 4; i++) push(i, 32'h8000_00A0 + 32'(i));
    push(0, 32'h8000_00A4);
    cyc("rr0", 4'b0001, 4'b0001, 0, 0, 32'h0);
    cyc("rr1", 4'b0010, 4'b0010, 0, 1, 32'h8000_00A0);
    cyc("rr2", 4'b0100, 4'b0100, 0, 1, 32'h8000_00A1);
    cyc("rr3", 4'b1000, 4'b1000, 0, 1, 32'h8000_00A2);
    cyc("rr4", 4'b0001, 4'b0001, 0, 1, 32'h8000_00A3);
    cyc("rr5", 4'b0000, 4'b0000, 0, 1, 32'h8000_00A4);
    // 3-flit packet on input 1 holds the link ahead of input 0
    push(1, 32'h0000_0011);
    push(1, 32'h0000_0012);
    push(1, 32'h8000_0013);
    push(0, 32'h8000_0001);
    cyc("lk0", 4'b0010, 4'b0010, 0, 0, 32'h0);
    cyc("lk1", 4'b0010, 4'b0010, 1, 1, 32'h0000_0011);
    cyc("lk2", 4'b0010, 4'b0010, 1, 1, 32'h0000_0012);
    cyc("lk3", 4'b0001, 4'b0001, 0, 1, 32'h8000_0013);
    cyc("lk4", 4'b0000, 4'b0000, 0, 1, 32'h8000_0001);
    // back-pressure holds the output flit and blocks pops
    push(2, 32'h8000_00B0);
    push(2, 32'h8000_00B1);
    cyc("bp0", 4'b0100, 4'b0100, 0, 0, 32'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("bp_hold", 4'b0000, 4'b0000, 0, 1, 32'h8000_00B0);
    out_ready = 1'b1;
    cyc("bp_rel", 4'b0100, 4'b0100, 0, 1, 32'h8000_00B0);
    cyc("bp_out", 4'b0000, 4'b0000, 0, 1, 32'h8000_00B1);
    // owner 3 starves mid-packet; inputs 0 and 2 must wait, then 0 wins after wrap
    push(3, 32'h0000_0031);
    push(0, 32'h8000_0040);
    push(2, 32'h8000_0042);
    cyc("st0", 4'b1000, 4'b1000, 0, 0, 32'h0);
    cyc("st1", 4'b0000, 4'b1000, 1, 1, 32'h0000_0031);
    cyc("st2", 4'b0000, 4'b1000, 1, 0, 32'h0);
    cyc("st3", 4'b0000, 4'b1000, 1, 0, 32'h0);
    push(3, 32'h8000_0033);
    cyc("st4", 4'b1000, 4'b1000, 1, 0, 32'h0);
    cyc("wrap0", 4'b0001, 4'b0001, 0, 1, 32'h8000_0033);
    cyc("wrap1", 4'b0100, 4'b0100, 0, 1, 32'h8000_0040);
    cyc("wrap2", 4'b0000, 4'b0000, 0, 1, 32'h8000_0042);
    // reset while input 2 owns the link with a flit held
    push(2, 32'h0000_0051);
    push(2, 32'h0000_0052);
    push(2, 32'h0000_0053);
    cyc("mr0", 4'b0100, 4'b0100, 0, 0, 32'h0);
    cyc("mr1", 4'b0100, 4'b0100, 1, 1, 32'h0000_0051);
    reset = 1'b1;
    push(0, 32'h8000_0060);
    @(negedge clk);
    chk("mr_force.en", 32'(in_read_en), 32'h0);
    @(posedge clk);
    #1;
    cyc("mr_rst", 4'b0000, 4'b0000, 0, 0, 32'h0);
    reset = 1'b0;
    cyc("mr_rel", 4'b0001, 4'b0001, 0, 0, 32'h0);
    cyc("mr_next", 4'b0100, 4'b0100, 0, 1, 32'h8000_0060);
    chk("fifo_err", 32'(fifo_err), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
